edge_pipe_buffer: RTL and testbench
===================================

// Module: edge_pipe_buffer
// PURPOSE
//  Parametrised elastic buffer for the RISC divider datapath; successor of the plain 32-bit falling-edge hold register.
//  Holds up to DEPTH words of WIDTH bits in order, with a valid/ready handshake on both sides, flush, and occupancy count.
//  All state updates occur on one selectable clock edge (falling by default), so stages on opposite edges can be decoupled.
// PARAMETERS
//  WIDTH     32  data word width in bits (>=1)
//  DEPTH     2   number of storage entries (>=1; need not be a power of 2)
//  NEGEDGE   1   1: all state updates on negedge clk; 0: on posedge clk
//  RESET_VAL 0   value driven on out_data whenever the buffer is empty (WIDTH bits)
// PORTS
//  clk        in   1                   single clock; active edge is selected by NEGEDGE
//  rst        in   1                   synchronous, active-high reset, sampled on the active edge
//  flush      in   1                   synchronous discard of all held words
//  in_valid   in   1                   producer has a word on in_data
//  in_ready   out  1                   buffer can accept a word (count < DEPTH)
//  in_data    in   WIDTH               write data
//  out_valid  out  1                   out_data holds the oldest word (count != 0)
//  out_ready  in   1                   consumer takes out_data at the next active edge
//  out_data   out  WIDTH               oldest held word; RESET_VAL when empty
//  count      out  $clog2(DEPTH+1)     number of words held, 0..DEPTH
// BEHAVIOUR
//  - Active edge (AE): negedge clk if NEGEDGE=1, else posedge. No logic uses the other edge.
//  - Reset at AE: count=0, rd_ptr=wr_ptr=0, all entries=RESET_VAL.
//    Outputs after reset: out_valid=0, in_ready=1, out_data=RESET_VAL, count=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated just before the AE.
//  - in_ready = (count < DEPTH). It is registered-state only; there is no combinational path from out_ready.
//  - When full, a push is refused even if a pop happens in the same cycle.
//  - DEPTH=1 gives at most one word per two AEs; DEPTH>=2 sustains one word per AE.
//  - out_valid = (count != 0). out_data = out_valid ? mem[rd_ptr] : RESET_VAL (mux from state only).
//  - Latency: a word pushed into an empty buffer appears on out_data/out_valid right after that same AE (1 AE).
//  - Ordering: strict FIFO order.
//  - Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0; no power-of-2 assumption.
//  - Count update at AE: push only => +1; pop only => -1; push & pop => unchanged, both pointers advance.
//  - Full (count=DEPTH): in_ready=0 and in_valid is ignored; contents are unchanged.
//  - Empty: out_valid=0 and out_ready is ignored; no underflow of pointers or count.
//  - Priority at AE: rst > flush > push/pop.
//  - flush: count=0, pointers=0, same-cycle push and pop are discarded; entries are not cleared (out_data masked to RESET_VAL).
//  - Reset or flush mid-stream drops all held words; the next pushed word is the first seen on the output.
//  - in_data is captured only on push. The upstream holds in_data/in_valid until accepted (standard valid/ready).
//  - No X propagation: all outputs are defined from the first AE after reset.
// TESTING (WIDTH=32, DEPTH=3, NEGEDGE=1 unless noted)
//  1. Reset, then push 0xA5A5_0001 with out_ready=0 -> after that falling edge: out_valid=1, out_data=0xA5A5_0001, count=1.
//  2. Push 0x1,0x2,0x3,0x4 back-to-back, out_ready=0 -> count=3, in_ready=0, 0x4 is not accepted.
//     Then set out_ready=1 -> out_data reads 0x1,0x2,0x3, then RESET_VAL with out_valid=0.
//  3. Stream 10 words with in_valid=out_ready=1 every cycle from empty -> one word per falling edge, count stays 1, pointers wrap 2->0 without loss.
//  4. Full at count=3, assert push and pop in the same cycle -> pop occurs, push refused, count=2; the refused word is accepted on the next edge.
//  5. Hold 2 words; assert flush with in_valid=1 -> count=0, out_valid=0, out_data=0; the pushed word is dropped.
//     Then assert rst mid-stream -> same result, and all outputs match reset values.
//  6. NEGEDGE=0, DEPTH=1 -> state changes only on rising edges; continuous valid/ready gives one word per 2 edges.
//     No output changes on falling edges.

Source files
------------

// File: rtl/edge_pipe_buffer_if.sv
// Handshake bundle for edge_pipe_buffer: producer side, consumer side and occupancy.
interface edge_pipe_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/edge_pipe_buffer.sv
// In-order elastic buffer of DEPTH words; 1 active-edge latency; in_ready depends on held count only.
// All state moves on the edge chosen by NEGEDGE so it can decouple stages running on opposite edges.
module edge_pipe_buffer #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter bit               NEGEDGE   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  edge_pipe_buffer_if.slave bus
);
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

  logic             ae_clk;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // NEGEDGE is a constant, so this is either a plain wire or a single clock inverter.
  assign ae_clk = NEGEDGE ? ~clk : clk;

  assign bus.in_ready  = (count_q < CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : RESET_VAL;
  assign bus.count     = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge ae_clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // Flushed entries keep stale data; the output mux hides them while empty.
      if (push && !flush) mem_q[wr_ptr_q] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_edge_pipe_buffer.sv
// Bench for edge_pipe_buffer: falling-edge DEPTH=3 instance plus a rising-edge DEPTH=1 instance.
module tb_edge_pipe_buffer;
  localparam int DA = 3;

  logic clk;
  logic rst_a, flush_a, rst_b, flush_b;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mq[$];

  edge_pipe_buffer_if #(.WIDTH(32), .DEPTH(DA)) bus_a ();
  edge_pipe_buffer_if #(.WIDTH(8),  .DEPTH(1))  bus_b ();

  edge_pipe_buffer #(.WIDTH(32), .DEPTH(DA), .NEGEDGE(1'b1), .RESET_VAL(32'h0)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a), .bus(bus_a)
  );
  edge_pipe_buffer #(.WIDTH(8), .DEPTH(1), .NEGEDGE(1'b0), .RESET_VAL(8'h0)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] din;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    int          ec;
    logic        er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r, logic f, logic iv, logic [31:0] d, logic o,
                              logic ev, logic [31:0] ed, int ec, logic er);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
    v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic o);
    rst_a = r; flush_a = f;
    bus_a.in_valid = iv; bus_a.in_data = d; bus_a.out_ready = o;
  endtask

  // Reference: a bounded queue; push seen against the occupancy before the edge.
  task automatic step_a();
    bit do_push, do_pop;
    do_push = bus_a.in_valid && (mq.size() < DA);
    do_pop  = bus_a.out_ready && (mq.size() != 0);
    @(negedge clk);
    if (rst_a || flush_a) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(bus_a.in_data);
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] ed;
    ed = (mq.size() != 0) ? mq[0] : 32'h0;
    chk({tag, ".valid"}, 32'(bus_a.out_valid), 32'(mq.size() != 0));
    chk({tag, ".data"},  bus_a.out_data, ed);
    chk({tag, ".count"}, 32'(bus_a.count), 32'(mq.size()));
    chk({tag, ".ready"}, 32'(bus_a.in_ready), 32'(mq.size() < DA));
  endtask

  initial begin
    logic [31:0] cur_d;
    logic        iv, o, f, r, acc;
    logic        sv, sr;
    logic [7:0]  sd;
    logic [7:0]  w;
    logic        sc;

    drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_b = 1'b1; flush_b = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h0; bus_b.out_ready = 1'b0;

    //   rst  fl   iv   data          ordy  ev   edata         ec  er
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'hA5A50001, 1'b0, 1'b1, 32'hA5A50001, 1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 1'b1, 32'h1,        1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h2,        1'b0, 1'b1, 32'h1,        2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h3,        1'b0, 1'b1, 32'h1,        3, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 1'b1, 32'h1,        3, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2,        2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3,        1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 1'b1, 32'h10,       1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h11,       1'b0, 1'b1, 32'h10,       2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h12,       1'b0, 1'b1, 32'h10,       3, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h13,       1'b1, 1'b1, 32'h11,       2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h13,       1'b0, 1'b1, 32'h11,       3, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h12,       2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h13,       1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h21,       1'b0, 1'b1, 32'h21,       1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h22,       1'b0, 1'b1, 32'h21,       2, 1'b1);
    add(1'b0, 1'b1, 1'b1, 32'h23,       1'b1, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h24,       1'b0, 1'b1, 32'h24,       1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h25,       1'b0, 1'b1, 32'h24,       2, 1'b1);
    add(1'b1, 1'b0, 1'b1, 32'h26,       1'b0, 1'b0, 32'h0,        0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h27,       1'b0, 1'b1, 32'h27,       1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1'b1);

    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      step_a();
      chk($sformatf("row%0d.valid", i), 32'(bus_a.out_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d.data", i),  bus_a.out_data, tbl[i].ed);
      chk($sformatf("row%0d.count", i), 32'(bus_a.count), 32'(tbl[i].ec));
      chk($sformatf("row%0d.ready", i), 32'(bus_a.in_ready), 32'(tbl[i].er));
    end

    // Streaming from empty: one word per falling edge, occupancy stays at one while pointers wrap.
    for (int k = 0; k < 10; k++) begin
      drive_a(1'b0, 1'b0, 1'b1, 32'h100 + 32'(k), 1'b1);
      step_a();
      chk($sformatf("stream%0d.data", k),  bus_a.out_data, 32'h100 + 32'(k));
      chk($sformatf("stream%0d.count", k), 32'(bus_a.count), 32'd1);
    end
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step_a();
    chk("stream_drain.valid", 32'(bus_a.out_valid), 32'd0);

    // Randomized traffic with occasional flush/reset, against the queue model.
    drive_a(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step_a();
    cur_d = $urandom;
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom_range(0, 3) != 0);
      o  = (n % 64 < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 40) == 0);
      r  = ($urandom_range(0, 80) == 0);
      drive_a(r, f, iv, cur_d, o);
      acc = iv && (mq.size() < DA);
      step_a();
      chk_model($sformatf("rand%0d", n));
      if (acc) cur_d = $urandom;
    end

    // Rising-edge DEPTH=1 instance: one word per two edges, nothing moves on falling edges.
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("b_reset.valid", 32'(bus_b.out_valid), 32'd0);
    chk("b_reset.ready", 32'(bus_b.in_ready), 32'd1);
    chk("b_reset.data",  32'(bus_b.out_data), 32'd0);
    chk("b_reset.count", 32'(bus_b.count), 32'd0);
    @(negedge clk); #1;
    rst_b = 1'b0;
    bus_b.in_valid = 1'b1;
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_b.in_data = 8'h30 + 8'((k + 1) / 2);
      @(posedge clk); #1;
      w  = 8'h30 + 8'(k / 2);
      sc = (k % 2 == 0);
      chk($sformatf("b%0d.valid", k), 32'(bus_b.out_valid), 32'(sc));
      chk($sformatf("b%0d.data", k),  32'(bus_b.out_data), sc ? 32'(w) : 32'h0);
      chk($sformatf("b%0d.ready", k), 32'(bus_b.in_ready), 32'(!sc));
      sv = bus_b.out_valid; sd = bus_b.out_data; sr = bus_b.in_ready;
      @(negedge clk); #1;
      chk($sformatf("b%0d.fall_valid", k), 32'(bus_b.out_valid), 32'(sv));
      chk($sformatf("b%0d.fall_data", k),  32'(bus_b.out_data), 32'(sd));
      chk($sformatf("b%0d.fall_ready", k), 32'(bus_b.in_ready), 32'(sr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
